// File: rtl/lsu_mmio_param.sv
// lsu_mmio_param: MEM-stage load/store unit for the RV32I pipeline.
// Handles DMEM, LED/HEX outputs, switch/key inputs and a 32-bit timer with a
// compare interrupt. Sub-word accesses use byte-lane enables, and misaligned
// accesses are flagged.
// Optional feature macro: LSU_SW_SYNC_EN adds a 2-flop synchronizer on
// i_io_sw and i_io_key in front of the read mux.
module lsu_mmio_param #(
    parameter int DMEM_AW = 11,
    parameter int LEDR_W  = 17,
    parameter int LEDG_W  = 8,
    parameter int NUM_HEX = 8,
    parameter int SW_W    = 17,
    parameter int KEY_W   = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [31:0]          i_lsu_addr,
    input  logic [31:0]          i_st_data,
    input  logic                 i_lsu_wren,
    input  logic                 i_lsu_rden,
    input  logic [2:0]           i_funct3,
    input  logic [SW_W-1:0]      i_io_sw,
    input  logic [KEY_W-1:0]     i_io_key,
    output logic [31:0]          o_ld_data,
    output logic                 o_ld_valid,
    output logic                 o_misalign,
    output logic [LEDR_W-1:0]    o_io_ledr,
    output logic [LEDG_W-1:0]    o_io_ledg,
    output logic [7*NUM_HEX-1:0] o_io_hex,
    output logic                 o_timer_irq
);
    // IO map as word addresses (byte address >> 2)
    localparam logic [13:0] WA_LEDR   = 14'h1C00;
    localparam logic [13:0] WA_LEDG   = 14'h1C04;
    localparam logic [13:0] WA_HEX0   = 14'h1C08;
    localparam logic [13:0] WA_SW     = 14'h1E00;
    localparam logic [13:0] WA_KEY    = 14'h1E04;
    localparam logic [13:0] WA_MTIME  = 14'h1E40;
    localparam logic [13:0] WA_MTCMP  = 14'h1E41;
    localparam logic [31:0] DMEM_BASE = 32'h0000_2000;
    localparam logic [31:0] DMEM_END  = DMEM_BASE + (32'd4 << DMEM_AW);

    logic [31:0]                r_dmem [0:(2**DMEM_AW)-1];
    logic [LEDR_W-1:0]          r_ledr;
    logic [LEDG_W-1:0]          r_ledg;
    logic [NUM_HEX-1:0][6:0]    r_hex;
    logic [31:0]                r_mtime, r_mtcmp;
    logic                       r_irq;
    logic [31:0]                r_ld_data;
    logic                       r_ld_valid, r_misal;

    logic [31:0]        w_a32, w_dmem_off, w_rd_word, w_sh, w_lane_d, w_mask;
    logic [31:0]        w_merged, w_ld_val, w_mtime_nx, w_mtcmp_nx;
    logic [13:0]        w_wa;
    logic [1:0]         w_bo;
    logic [DMEM_AW-1:0] w_dmem_idx;
    logic [3:0]         w_be;
    logic               w_sel_dmem, w_is_b, w_is_h, w_is_w, w_uns, w_legal, w_misal;
    logic               w_wr, w_rd;
    logic [SW_W-1:0]    w_sw;
    logic [KEY_W-1:0]   w_key;
    logic               w_unused;

    assign w_a32      = {16'h0, i_lsu_addr[15:0]};
    assign w_wa       = i_lsu_addr[15:2];
    assign w_bo       = i_lsu_addr[1:0];
    assign w_dmem_off = w_a32 - DMEM_BASE;
    assign w_dmem_idx = w_dmem_off[DMEM_AW+1:2];
    assign w_sel_dmem = (w_a32 >= DMEM_BASE) && (w_a32 < DMEM_END);
    assign w_unused   = ^{i_lsu_addr[31:16], w_dmem_off, w_sh[31:16]};

`ifdef LSU_SW_SYNC_EN
    logic [SW_W-1:0]  r_sw_s1, r_sw_s2;
    logic [KEY_W-1:0] r_key_s1, r_key_s2;

    // two-flop synchronizer for the asynchronous switch/key pins
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sw_s1  <= '0;
            r_sw_s2  <= '0;
            r_key_s1 <= '0;
            r_key_s2 <= '0;
        end else begin
            r_sw_s1  <= i_io_sw;
            r_sw_s2  <= r_sw_s1;
            r_key_s1 <= i_io_key;
            r_key_s2 <= r_key_s1;
        end
    end
    assign w_sw  = r_sw_s2;
    assign w_key = r_key_s2;
`else
    assign w_sw  = i_io_sw;
    assign w_key = i_io_key;
`endif

    // access size decode, alignment check and byte-lane enables
    always_comb begin
        w_is_b  = (i_funct3 == 3'b000) || (i_funct3 == 3'b100);
        w_is_h  = (i_funct3 == 3'b001) || (i_funct3 == 3'b101);
        w_is_w  = (i_funct3 == 3'b010);
        w_uns   = i_funct3[2];
        w_legal = w_is_b | w_is_h | w_is_w;
        w_misal = (w_is_h & w_bo[0]) | (w_is_w & (w_bo != 2'b00));
        w_be    = 4'b0000;
        if (w_is_b)      w_be[w_bo] = 1'b1;
        else if (w_is_h) w_be = w_bo[1] ? 4'b1100 : 4'b0011;
        else if (w_is_w) w_be = 4'b1111;
        w_lane_d = w_is_b ? {4{i_st_data[7:0]}} :
                   w_is_h ? {2{i_st_data[15:0]}} : i_st_data;
        w_mask = 32'h0;
        for (int b = 0; b < 4; b++)
            if (w_be[b]) w_mask[8*b +: 8] = 8'hFF;
        // store wins over a simultaneous load
        w_wr = i_lsu_wren & w_legal & ~w_misal;
        w_rd = i_lsu_rden & ~i_lsu_wren;
    end

    // word read mux; narrow registers zero-extend, unmapped reads 0
    always_comb begin
        w_rd_word = 32'h0;
        if (w_sel_dmem)            w_rd_word = r_dmem[w_dmem_idx];
        if (w_wa == WA_LEDR)       w_rd_word = 32'(r_ledr);
        if (w_wa == WA_LEDG)       w_rd_word = 32'(r_ledg);
        if (w_wa == WA_SW)         w_rd_word = 32'(w_sw);
        if (w_wa == WA_KEY)        w_rd_word = 32'(w_key);
        if (w_wa == WA_MTIME)      w_rd_word = r_mtime;
        if (w_wa == WA_MTCMP)      w_rd_word = r_mtcmp;
        for (int k = 0; k < NUM_HEX; k++)
            if (w_wa == WA_HEX0 + 14'(k)) w_rd_word = {25'h0, r_hex[k]};
    end

    // lane merge used by every register write (DMEM writes bytes directly)
    assign w_merged = (w_rd_word & ~w_mask) | (w_lane_d & w_mask);

    // sub-word extraction with sign/zero extension
    always_comb begin
        w_sh     = w_rd_word >> {w_bo, 3'b000};
        w_ld_val = 32'h0;
        if (w_legal && !w_misal) begin
            if (w_is_w)      w_ld_val = w_rd_word;
            else if (w_is_h) w_ld_val = w_uns ? {16'h0, w_sh[15:0]} : {{16{w_sh[15]}}, w_sh[15:0]};
            else             w_ld_val = w_uns ? {24'h0, w_sh[7:0]}  : {{24{w_sh[7]}},  w_sh[7:0]};
        end
    end

    // timer next state: a store to mtime replaces the increment
    always_comb begin
        w_mtime_nx = r_mtime + 32'd1;
        if (w_wr && (w_wa == WA_MTIME)) w_mtime_nx = w_merged;
        w_mtcmp_nx = r_mtcmp;
        if (w_wr && (w_wa == WA_MTCMP)) w_mtcmp_nx = w_merged;
    end

    // DMEM byte-lane writes; contents survive reset, requests in reset dropped
    always_ff @(posedge i_clk) begin
        if (i_rst_n && w_wr && w_sel_dmem)
            for (int b = 0; b < 4; b++)
                if (w_be[b]) r_dmem[w_dmem_idx][8*b +: 8] <= w_lane_d[8*b +: 8];
    end

    // LED and HEX output registers
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_ledr <= '0;
            r_ledg <= '0;
            r_hex  <= {NUM_HEX{7'h7F}};
        end else if (w_wr) begin
            if (w_wa == WA_LEDR) r_ledr <= w_merged[LEDR_W-1:0];
            if (w_wa == WA_LEDG) r_ledg <= w_merged[LEDG_W-1:0];
            for (int k = 0; k < NUM_HEX; k++)
                if (w_wa == WA_HEX0 + 14'(k)) r_hex[k] <= w_merged[6:0];
        end
    end

    // timer registers and registered compare interrupt
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_mtime <= 32'h0;
            r_mtcmp <= 32'hFFFF_FFFF;
            r_irq   <= 1'b0;
        end else begin
            r_mtime <= w_mtime_nx;
            r_mtcmp <= w_mtcmp_nx;
            r_irq   <= (w_mtime_nx >= w_mtcmp_nx);
        end
    end

    // registered load result and status strobes
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_ld_data  <= 32'h0;
            r_ld_valid <= 1'b0;
            r_misal    <= 1'b0;
        end else begin
            r_ld_valid <= w_rd;
            r_misal    <= (i_lsu_wren | i_lsu_rden) & w_misal;
            if (w_rd) r_ld_data <= w_ld_val;
        end
    end

    assign o_ld_data   = r_ld_data;
    assign o_ld_valid  = r_ld_valid;
    assign o_misalign  = r_misal;
    assign o_io_ledr   = r_ledr;
    assign o_io_ledg   = r_ledg;
    assign o_io_hex    = r_hex;
    assign o_timer_irq = r_irq;

endmodule

// File: tb/tb_lsu_mmio_param.sv
// Bench for lsu_mmio_param: byte-addressed reference model plus literal checks.
module tb_lsu_mmio_param;
    localparam int DMEM_AW = 11, LEDR_W = 17, LEDG_W = 8, NUM_HEX = 8, SW_W = 17, KEY_W = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst_n = 1'b0, wren = 1'b0, rden = 1'b0;
    logic [31:0]          addr = 32'h0, sdata = 32'h0;
    logic [2:0]           f3 = 3'b010;
    logic [SW_W-1:0]      sw = '0;
    logic [KEY_W-1:0]     key = '0;
    logic [31:0]          ld_data;
    logic                 ld_valid, misalign, irq;
    logic [LEDR_W-1:0]    ledr;
    logic [LEDG_W-1:0]    ledg;
    logic [7*NUM_HEX-1:0] hex;

    lsu_mmio_param #(.DMEM_AW(DMEM_AW), .LEDR_W(LEDR_W), .LEDG_W(LEDG_W),
                     .NUM_HEX(NUM_HEX), .SW_W(SW_W), .KEY_W(KEY_W)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_lsu_addr(addr), .i_st_data(sdata),
        .i_lsu_wren(wren), .i_lsu_rden(rden), .i_funct3(f3),
        .i_io_sw(sw), .i_io_key(key),
        .o_ld_data(ld_data), .o_ld_valid(ld_valid), .o_misalign(misalign),
        .o_io_ledr(ledr), .o_io_ledg(ledg), .o_io_hex(hex), .o_timer_irq(irq));

    int checks = 0, failures = 0;

    // reference model: DMEM as a sparse byte array, IO as plain registers
    logic [7:0]  mem [int];
    logic [31:0] m_ledr, m_ledg, m_mtime, m_mtcmp, m_ld, m_s1sw, m_s2sw, m_s1key, m_s2key;
    logic [6:0]  m_hex [16];
    logic        m_irq, m_vld, m_mis;
    bit          mt_wr;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    function automatic bit in_dmem(input int a);
        return a >= 'h2000 && a < 'h2000 + (4 << DMEM_AW);
    endfunction

    function automatic logic [31:0] io_word(input int wa);
        logic [31:0] w;
        w = 32'h0;
        if (wa == 'h7000)      w = m_ledr;
        else if (wa == 'h7010) w = m_ledg;
        else if (wa >= 'h7020 && wa < 'h7020 + 4*NUM_HEX) w = {25'h0, m_hex[(wa - 'h7020) / 4]};
`ifdef LSU_SW_SYNC_EN
        else if (wa == 'h7800) w = m_s2sw;
        else if (wa == 'h7810) w = m_s2key;
`else
        else if (wa == 'h7800) w = 32'(sw);
        else if (wa == 'h7810) w = 32'(key);
`endif
        else if (wa == 'h7900) w = m_mtime;
        else if (wa == 'h7904) w = m_mtcmp;
        return w;
    endfunction

    function automatic logic [7:0] rd_byte(input int a);
        logic [31:0] w;
        if (in_dmem(a)) return mem.exists(a) ? mem[a] : 8'h00;
        w = io_word(a - (a % 4)) >> (8 * (a % 4));
        return w[7:0];
    endfunction

    function automatic void wr_byte(input int a, input logic [7:0] b);
        logic [31:0] w;
        int wa;
        if (in_dmem(a)) begin
            mem[a] = b;
            return;
        end
        wa = a - (a % 4);
        w = io_word(wa);
        w[8*(a%4) +: 8] = b;
        if (wa == 'h7000)      m_ledr = 32'(w[LEDR_W-1:0]);
        else if (wa == 'h7010) m_ledg = 32'(w[LEDG_W-1:0]);
        else if (wa >= 'h7020 && wa < 'h7020 + 4*NUM_HEX) m_hex[(wa - 'h7020) / 4] = w[6:0];
        else if (wa == 'h7900) begin m_mtime = w; mt_wr = 1'b1; end
        else if (wa == 'h7904) m_mtcmp = w;
    endfunction

    // one clock: drive request, advance model, then compare every output
    task automatic step(input logic r, input logic w, input logic rd,
                        input logic [31:0] ad, input logic [31:0] d, input logic [2:0] fn);
        int a, sz;
        logic mis, legal;
        logic [31:0] v;
        logic [7*NUM_HEX-1:0] eh;
        @(negedge clk);
        rst_n = r; wren = w; rden = rd; addr = ad; sdata = d; f3 = fn;
        a  = int'(ad[15:0]);
        sz = (fn == 3'd0 || fn == 3'd4) ? 1 : (fn == 3'd1 || fn == 3'd5) ? 2 : (fn == 3'd2) ? 4 : 0;
        legal = (sz != 0);
        mis   = legal && ((a % sz) != 0);
        if (!r) begin
            m_ledr = 0; m_ledg = 0; m_mtime = 0; m_mtcmp = 32'hFFFF_FFFF; m_irq = 0;
            m_ld = 0; m_vld = 0; m_mis = 0;
            m_s1sw = 0; m_s2sw = 0; m_s1key = 0; m_s2key = 0;
            for (int k = 0; k < 16; k++) m_hex[k] = 7'h7F;
        end else begin
            m_vld = rd && !w;
            m_mis = (w || rd) && mis;
            if (m_vld) begin
                v = 32'h0;
                if (legal && !mis) begin
                    for (int i = 0; i < sz; i++) v[8*i +: 8] = rd_byte(a + i);
                    if (sz == 1 && !fn[2]) v = {{24{v[7]}}, v[7:0]};
                    if (sz == 2 && !fn[2]) v = {{16{v[15]}}, v[15:0]};
                end
                m_ld = v;
            end
            mt_wr = 1'b0;
            if (w && legal && !mis)
                for (int i = 0; i < sz; i++) wr_byte(a + i, d[8*i +: 8]);
            if (!mt_wr) m_mtime = m_mtime + 32'd1;
            m_s2sw = m_s1sw; m_s1sw = 32'(sw);
            m_s2key = m_s1key; m_s1key = 32'(key);
            m_irq = (m_mtime >= m_mtcmp);
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < NUM_HEX; k++) eh[7*k +: 7] = m_hex[k];
        chk("ld_valid", 64'(ld_valid), 64'(m_vld));
        chk("misalign", 64'(misalign), 64'(m_mis));
        chk("ld_data",  64'(ld_data),  64'(m_ld));
        chk("ledr",     64'(ledr),     64'(m_ledr));
        chk("ledg",     64'(ledg),     64'(m_ledg));
        chk("hex",      64'(hex),      64'(eh));
        chk("irq",      64'(irq),      64'(m_irq));
    endtask

    task automatic st(input logic [31:0] a, input logic [31:0] d, input logic [2:0] fn);
        step(1'b1, 1'b1, 1'b0, a, d, fn);
    endtask
    task automatic ld(input logic [31:0] a, input logic [2:0] fn);
        step(1'b1, 1'b0, 1'b1, a, 32'h0, fn);
    endtask
    task automatic idle();
        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 3'b010);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

    initial begin
        logic [7*NUM_HEX-1:0] hx;
        int first;
        // reset with requests present: they must be dropped
        step(1'b0, 1'b0, 1'b1, 32'h2004, 32'h0, 3'b010);
        step(1'b0, 1'b1, 1'b0, 32'h7000, 32'hFFFF, 3'b010);
        chk("rst_ledr", 64'(ledr), 64'h0);
        chk("rst_hex",  64'(hex),  64'h00FF_FFFF_FFFF_FFFF);
        chk("rst_irq",  64'(irq),  64'h0);
        chk("rst_vld",  64'(ld_valid), 64'h0);
        idle();
        chk("post_rst_vld", 64'(ld_valid), 64'h0);
        ld(32'h7900, 3'b010);          chk("mtime_1", 64'(ld_data), 64'h1);

        st(32'h2004, 32'hDEADBEEF, 3'b010);
        ld(32'h2004, 3'b010);          chk("lw_dead", 64'(ld_data), 64'hDEADBEEF);
        chk("lw_vld", 64'(ld_valid), 64'h1);
        st(32'h2005, 32'h12, 3'b000);
        ld(32'h2005, 3'b000);          chk("lb",   64'(ld_data), 64'h12);
        ld(32'h2005, 3'b100);          chk("lbu",  64'(ld_data), 64'h12);
        ld(32'h2006, 3'b001);          chk("lh",   64'(ld_data), 64'hFFFFDEAD);
        ld(32'h2007, 3'b000);          chk("lb_neg", 64'(ld_data), 64'hFFFFFFDE);
        ld(32'h2006, 3'b101);          chk("lhu",  64'(ld_data), 64'h0000DEAD);
        ld(32'h2004, 3'b010);          chk("lw_merged", 64'(ld_data), 64'hDEAD12EF);

        st(32'h2002, 32'h55, 3'b010);  chk("sw_mis", 64'(misalign), 64'h1);
        ld(32'h2003, 3'b001);          chk("lh_mis", 64'(misalign), 64'h1);
        chk("lh_mis_vld", 64'(ld_valid), 64'h1);
        chk("lh_mis_data", 64'(ld_data), 64'h0);
        ld(32'h2004, 3'b010);          chk("mem_kept", 64'(ld_data), 64'hDEAD12EF);

        st(32'h7000, 32'hFF, 3'b011);  chk("ill_st", 64'(ledr), 64'h0);
        chk("ill_nomis", 64'(misalign), 64'h0);
        ld(32'h2005, 3'b111);          chk("ill_ld", 64'(ld_data), 64'h0);

        step(1'b1, 1'b1, 1'b1, 32'h2008, 32'hCAFEF00D, 3'b010);
        chk("both_novld", 64'(ld_valid), 64'h0);
        ld(32'h2008, 3'b010);          chk("raw", 64'(ld_data), 64'hCAFEF00D);
        ld(32'h2004, 3'b010);

        st(32'h7000, 32'hFFFFFFFF, 3'b010); chk("ledr_full", 64'(ledr), 64'h1FFFF);
        st(32'h7010, 32'hA5, 3'b000);
        st(32'h7012, 32'h1234, 3'b001);     chk("ledg_hi_drop", 64'(ledg), 64'hA5);
        st(32'h7024, 32'h40, 3'b010);
        hx = {NUM_HEX{7'h7F}};
        hx[13:7] = 7'h40;
        chk("hex1", 64'(hex), 64'(hx));
        ld(32'h7024, 3'b010);          chk("hex_rd", 64'(ld_data), 64'h40);
        ld(32'h7000, 3'b000);          chk("ledr_lb", 64'(ld_data), 64'hFFFFFFFF);
        ld(32'h7002, 3'b101);          chk("ledr_lhu", 64'(ld_data), 64'h1);
        st(32'h703C, 32'h00, 3'b010);  // last digit

        st(32'h5000, 32'h1234, 3'b010);
        ld(32'h5000, 3'b010);          chk("unmapped", 64'(ld_data), 64'h0);
        st(32'h3FFC, 32'h11223344, 3'b010);
        ld(32'h3FFC, 3'b010);          chk("dmem_top", 64'(ld_data), 64'h11223344);
        ld(32'h4000, 3'b010);          chk("dmem_past", 64'(ld_data), 64'h0);

        st(32'h7904, 32'd10, 3'b010);
        st(32'h7900, 32'd5, 3'b010);
        first = 0;
        for (int k = 1; k <= 8; k++) begin
            idle();
            if (irq && first == 0) first = k;
        end
        chk("irq_delay", 64'(first), 64'd5);
        ld(32'h7904, 3'b010);          chk("mtcmp_rd", 64'(ld_data), 64'd10);
        st(32'h7900, 32'hFFFFFFFF, 3'b010); chk("irq_max", 64'(irq), 64'h1);
        idle();                        chk("irq_wrap", 64'(irq), 64'h0);
        ld(32'h7900, 3'b010);          chk("mtime_wrap", 64'(ld_data), 64'h0);

        sw = 17'h1ABCD; key = 4'h9;
        idle(); idle();
        ld(32'h7800, 3'b010);          chk("sw_rd", 64'(ld_data), 64'h0001ABCD);
        ld(32'h7810, 3'b100);          chk("key_rd", 64'(ld_data), 64'h9);
        sw = 17'h00055;
        ld(32'h7800, 3'b010);
        ld(32'h7800, 3'b010);
        ld(32'h7800, 3'b010);          chk("sw_new", 64'(ld_data), 64'h55);

        step(1'b0, 1'b1, 1'b0, 32'h2004, 32'h0, 3'b010);
        chk("mid_rst_ledr", 64'(ledr), 64'h0);
        chk("mid_rst_ledg", 64'(ledg), 64'h0);
        chk("mid_rst_hex",  64'(hex),  64'h00FF_FFFF_FFFF_FFFF);
        idle();
        ld(32'h2004, 3'b010);          chk("dmem_no_rst", 64'(ld_data), 64'hDEAD12EF);
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
